// File: rtl/contador_comparacoes.sv
// contador_comparacoes: debounced capture of the 4-bit comparator flags,
// with saturating per-outcome tallies and a short history for the LEDs.
module contador_comparacoes #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 8,
   parameter int HIST_DEPTH      = 4
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    key_n,
   input  logic                    maior,
   input  logic                    igual,
   input  logic                    menor,
   output logic [CNT_W-1:0]        count_maior,
   output logic [CNT_W-1:0]        count_igual,
   output logic [CNT_W-1:0]        count_menor,
   output logic [2:0]              ultimo,
   output logic [3*HIST_DEPTH-1:0] historico,
   output logic                    captura,
   output logic                    erro
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = 3 * HIST_DEPTH;
   localparam logic [CW-1:0] ULTIMO_CNT = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      solto,
      filtra_aperto,
      apertado,
      filtra_soltura
   } estado_t;

   estado_t         estado;
   logic [CW-1:0]   cnt;
   logic            sync1;
   logic            key_s;
   logic            pend;
   logic [2:0]      amostra;
   logic            amostra_ok;

   assign amostra_ok = (amostra == 3'b100) ||
                       (amostra == 3'b010) ||
                       (amostra == 3'b001);

   // Flags are latched on entry to apertado and committed one edge later,
   // so captura and all updated outputs appear together.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1       <= 1'b1;
         key_s       <= 1'b1;
         estado      <= solto;
         cnt         <= '0;
         pend        <= 1'b0;
         amostra     <= 3'b000;
         count_maior <= '0;
         count_igual <= '0;
         count_menor <= '0;
         ultimo      <= 3'b000;
         historico   <= '0;
         captura     <= 1'b0;
         erro        <= 1'b0;
      end else begin
         sync1   <= key_n;
         key_s   <= sync1;
         pend    <= 1'b0;
         captura <= 1'b0;

         unique case (estado)
            solto: begin
               if (!key_s) begin
                  estado <= filtra_aperto;
                  cnt    <= '0;
               end
            end
            filtra_aperto: begin
               if (key_s) begin
                  estado <= solto;
               end else if (cnt == ULTIMO_CNT) begin
                  estado  <= apertado;
                  pend    <= 1'b1;
                  amostra <= {maior, igual, menor};
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            apertado: begin
               if (key_s) begin
                  estado <= filtra_soltura;
                  cnt    <= '0;
               end
            end
            filtra_soltura: begin
               if (!key_s) begin
                  estado <= apertado;
               end else if (cnt == ULTIMO_CNT) begin
                  estado <= solto;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: estado <= solto;
         endcase

         if (pend) begin
            captura <= 1'b1;
            if (amostra_ok) begin
               ultimo    <= amostra;
               historico <= HW'({historico, amostra});
               unique case (1'b1)
                  amostra[2]: begin
                     if (count_maior != '1)
                        count_maior <= count_maior + CNT_W'(1);
                  end
                  amostra[1]: begin
                     if (count_igual != '1)
                        count_igual <= count_igual + CNT_W'(1);
                  end
                  amostra[0]: begin
                     if (count_menor != '1)
                        count_menor <= count_menor + CNT_W'(1);
                  end
               endcase
            end else begin
               ultimo    <= 3'b000;
               historico <= HW'({historico, 3'b000});
               erro      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_contador_comparacoes.sv
// tb_contador_comparacoes: scoreboard bench with a queue-based
// reference model of tallies, history and sticky error.
module tb_contador_comparacoes;

   localparam int D  = 4;
   localparam int CW = 4;
   localparam int HD = 4;
   localparam int SAT = (1 << CW) - 1;

   logic            clk;
   logic            reset;
   logic            key_n;
   logic            maior, igual, menor;
   logic [CW-1:0]   count_maior, count_igual, count_menor;
   logic [2:0]      ultimo;
   logic [3*HD-1:0] historico;
   logic            captura;
   logic            erro;

   contador_comparacoes #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(CW),
      .HIST_DEPTH(HD)
   ) dut (
      .CLOCK_50(clk),
      .reset(reset),
      .key_n(key_n),
      .maior(maior),
      .igual(igual),
      .menor(menor),
      .count_maior(count_maior),
      .count_igual(count_igual),
      .count_menor(count_menor),
      .ultimo(ultimo),
      .historico(historico),
      .captura(captura),
      .erro(erro)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         when;
      int         cm, ci, cn;
      logic [2:0] u;
      logic [11:0] h;
      logic       e;
   } exp_t;

   exp_t sb[$];

   // reference model state
   int         m_cnt[3];
   logic [2:0] m_hist[$];
   logic [2:0] m_ult;
   logic       m_err;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [11:0] m_hist_vec();
      return {m_hist[3], m_hist[2], m_hist[1], m_hist[0]};
   endfunction

   task automatic model_reset();
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_cnt[2] = 0;
      m_hist = '{3'b000, 3'b000, 3'b000, 3'b000};
      m_ult = 3'b000;
      m_err = 1'b0;
   endtask

   task automatic model_capture(logic [2:0] f, int when);
      exp_t x;
      logic [2:0] v;
      int idx;
      idx = -1;
      if (f == 3'b100) idx = 0;
      if (f == 3'b010) idx = 1;
      if (f == 3'b001) idx = 2;
      if (idx >= 0) begin
         if (m_cnt[idx] < SAT) m_cnt[idx] = m_cnt[idx] + 1;
         v = f;
      end else begin
         v = 3'b000;
         m_err = 1'b1;
      end
      m_ult = v;
      m_hist.push_front(v);
      void'(m_hist.pop_back());
      x.when = when;
      x.cm = m_cnt[0];
      x.ci = m_cnt[1];
      x.cn = m_cnt[2];
      x.u = m_ult;
      x.h = m_hist_vec();
      x.e = m_err;
      sb.push_back(x);
   endtask

   // monitor: every captura pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && captura) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_captura: got 1 expected 0 at cycle %0d",
                     cyc);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("latency", cyc, x.when);
            chk("count_maior", count_maior, x.cm);
            chk("count_igual", count_igual, x.ci);
            chk("count_menor", count_menor, x.cn);
            chk("ultimo", ultimo, x.u);
            chk("historico", historico, x.h);
            chk("erro", erro, x.e);
         end
      end
   end

   task automatic check_model(string tag);
      chk({tag, "_count_maior"}, count_maior, m_cnt[0]);
      chk({tag, "_count_igual"}, count_igual, m_cnt[1]);
      chk({tag, "_count_menor"}, count_menor, m_cnt[2]);
      chk({tag, "_ultimo"}, ultimo, m_ult);
      chk({tag, "_historico"}, historico, m_hist_vec());
      chk({tag, "_erro"}, erro, m_err);
   endtask

   task automatic drain(string tag);
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_missing_captura: got 0 expected %0d pulses",
                  tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      key_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("rst_count_maior", count_maior, 0);
      chk("rst_count_igual", count_igual, 0);
      chk("rst_count_menor", count_menor, 0);
      chk("rst_ultimo", ultimo, 0);
      chk("rst_historico", historico, 0);
      chk("rst_captura", captura, 0);
      chk("rst_erro", erro, 0);
   endtask

   // mode 0: steady flags; 1: flags switch to 001 mid-hold;
   // 2: random flag changes and short high glitches after capture
   task automatic press(logic [2:0] f, int hold, int mode);
      @(negedge clk);
      {maior, igual, menor} = f;
      key_n = 1'b0;
      model_capture(f, cyc + D + 4);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         key_n = 1'b0;
         if (mode == 1 && i == hold / 2)
            {maior, igual, menor} = 3'b001;
         if (mode == 2 && i >= D + 4) begin
            {maior, igual, menor} = 3'($urandom_range(0, 7));
            if (i < hold - 2 && $urandom_range(0, 5) == 0)
               key_n = 1'b1;
         end
      end
   endtask

   task automatic release_key(int n);
      @(negedge clk);
      key_n = 1'b1;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic bounce(int low_len, int gap);
      @(negedge clk);
      key_n = 1'b0;
      repeat (low_len - 1) @(negedge clk);
      @(negedge clk);
      key_n = 1'b1;
      repeat (gap - 1) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      key_n = 1'b1;
      {maior, igual, menor} = 3'b000;
      model_reset();
      do_reset();

      // clean press
      press(3'b100, 20, 0);
      drain("clean");
      release_key(10);
      chk("clean_count_maior", count_maior, 1);
      chk("clean_ultimo", ultimo, 3'b100);
      chk("clean_historico", historico, 12'b000000000100);

      // bounce rejection, then a press proves the FSM is back in solto
      do_reset();
      bounce(3, 1);
      bounce(3, 12);
      chk("bounce_count_maior", count_maior, 0);
      chk("bounce_count_igual", count_igual, 0);
      chk("bounce_count_menor", count_menor, 0);
      press(3'b100, 12, 0);
      drain("bounce");
      release_key(10);

      // held press with mid-hold flag change, then mixed sequence
      do_reset();
      press(3'b010, 100, 1);
      drain("held");
      chk("held_ultimo", ultimo, 3'b010);
      release_key(10);
      press(3'b001, 12, 0);
      release_key(10);
      press(3'b100, 12, 0);
      release_key(10);
      drain("mixed");
      chk("mixed_historico", historico, 12'b000010001100);
      chk("mixed_maior", count_maior, 1);
      chk("mixed_igual", count_igual, 1);
      chk("mixed_menor", count_menor, 1);

      // saturation
      do_reset();
      for (int n = 1; n <= 17; n++) begin
         press(3'b001, 10, 0);
         release_key(9);
         drain("sat");
         if (n == 15) chk("sat15_count_menor", count_menor, SAT);
      end
      chk("sat_count_menor", count_menor, SAT);
      chk("sat_count_maior", count_maior, 0);
      chk("sat_count_igual", count_igual, 0);

      // invalid flags, then a valid press keeps erro
      press(3'b110, 10, 0);
      release_key(10);
      drain("inv");
      check_model("inv");
      chk("inv_erro", erro, 1);
      chk("inv_ultimo", ultimo, 3'b000);
      press(3'b010, 10, 0);
      release_key(10);
      drain("inv2");
      chk("inv2_erro", erro, 1);

      // reset two cycles into the press filter
      @(negedge clk);
      {maior, igual, menor} = 3'b100;
      key_n = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      key_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (20) @(negedge clk);
      check_model("midrst");
      chk("midrst_captura", captura, 0);
      press(3'b100, 20, 0);
      drain("midrst_clean");
      release_key(10);
      chk("midrst_count_maior", count_maior, 1);
      chk("midrst_ultimo", ultimo, 3'b100);
      chk("midrst_historico", historico, 12'b000000000100);

      // randomized presses with glitches
      do_reset();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0)
            bounce($urandom_range(1, 3), $urandom_range(2, 4));
         press(3'($urandom_range(0, 7)), $urandom_range(D + 6, 25), 2);
         release_key($urandom_range(9, 14));
         drain("rand");
         check_model("rand");
      end

      drain("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
